// File: rtl/prog_loader_pkg.sv
// Shared constants for the boot-time program loader: FSM encoding, stream framing
// sizes and the default load address (also the core's PC reset value).
package prog_loader_pkg;

    localparam logic [2:0] ST_HDR   = 3'd0;
    localparam logic [2:0] ST_DATA  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_CHK   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Little-endian byte-to-word packer: one byte per accepted transfer, lane counter
// wraps after the last lane, word_ready marks the byte that completes a word.
module prog_loader_byte_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);

    localparam int unsigned LANE_W = $clog2(WORD_BYTES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);
    localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);

    logic [31:0]       pack_r;
    logic [LANE_W-1:0] lane_r;

    assign word_ready = byte_valid && (lane_r == LAST_LANE);

    // Merge the incoming byte so a completing byte is usable in the same cycle
    always_comb begin
        word = pack_r;
        if (byte_valid) begin
            word[{lane_r, 3'b000} +: 8] = byte_data;
        end else begin
            word = pack_r;
        end
    end

    // Lane counter and partial-word storage
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_r <= 32'd0;
            lane_r <= {LANE_W{1'b0}};
        end else if (byte_valid) begin
            lane_r <= lane_r + LANE_ONE;
            pack_r <= word_ready ? 32'd0 : word;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: byte stream -> 32-bit memory writes, core held in reset
// until the image is loaded. Define PROG_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS + 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [31:0] MAX_COUNT = 32'(MEM_WORDS);
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_FINAL = ST_CHK;
`else
    localparam logic [2:0] ST_FINAL = ST_DONE;
`endif

    logic [2:0]       state_r;
    logic [2:0]       state_s;
    logic             accept_s;
    logic             asm_valid_s;
    logic             word_ready_s;
    logic             last_s;
    logic             in_ready_s;
    logic             busy_s;
    logic [31:0]      word_s;
    logic [31:0]      addr_s;
    logic [31:0]      count_r;
    logic [IDX_W-1:0] index_r;
    logic             in_ready_r;
    logic             mem_we_r;
    logic [31:0]      mem_addr_r;
    logic [31:0]      mem_wdata_r;
    logic             core_rst_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]       csum_r;
`endif

    assign accept_s    = in_valid && in_ready_r;
    assign asm_valid_s = accept_s && ((state_r == ST_HDR) || (state_r == ST_DATA));
    assign last_s      = ((32'(index_r) + 32'd1) == count_r);
    assign addr_s      = BASE_ADDR + 32'({index_r, 2'b00});

    prog_loader_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (asm_valid_s),
        .byte_data  (in_data),
        .word       (word_s),
        .word_ready (word_ready_s)
    );

    // Next-state logic; the header word is judged as its last byte arrives
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_HDR: begin
                if (!word_ready_s) begin
                    state_s = ST_HDR;
                end else if (word_s == 32'd0) begin
                    state_s = ST_FINAL;
                end else if (word_s > MAX_COUNT) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_ready_s) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_WRITE: begin
                if (last_s) begin
                    state_s = ST_FINAL;
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (!accept_s) begin
                    state_s = ST_CHK;
                end else if (in_data == csum_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ERR;
                end
            end
`endif
            ST_DONE: state_s = ST_DONE;
            ST_ERR:  state_s = ST_ERR;
            default: state_s = ST_ERR;
        endcase
    end

    // Output decode from the state being entered, so outputs can be registered
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
        case (state_s)
            ST_HDR: begin
                in_ready_s = 1'b1;
                busy_s     = busy_r || accept_s;
            end
            ST_DATA: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
            ST_WRITE: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b1;
            end
            ST_CHK: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // FSM state, load bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_HDR;
            count_r     <= 32'd0;
            index_r     <= {IDX_W{1'b0}};
            in_ready_r  <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= BASE_ADDR;
            mem_wdata_r <= 32'd0;
            core_rst_r  <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r == ST_HDR) && word_ready_s) begin
                count_r <= word_s;
            end
            if (state_r == ST_HDR) begin
                index_r <= {IDX_W{1'b0}};
            end else if (state_r == ST_WRITE) begin
                index_r <= index_r + IDX_ONE;
            end
            mem_we_r <= (state_r == ST_DATA) && word_ready_s;
            if ((state_r == ST_DATA) && word_ready_s) begin
                mem_addr_r  <= addr_s;
                mem_wdata_r <= word_s;
            end
            in_ready_r <= in_ready_s;
            busy_r     <= busy_s;
            core_rst_r <= (state_s != ST_DONE);
            done_r     <= (state_s == ST_DONE);
            err_r      <= (state_s == ST_ERR);
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running XOR over payload bytes only; the header is excluded
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_r <= 8'h00;
        end else if ((state_r == ST_DATA) && accept_s) begin
            csum_r <= csum_r ^ in_data;
        end
    end
`endif

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign core_rst  = core_rst_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader: images are built as byte lists, the expected
// writes and final status are derived from the image itself, then compared.
module tb_prog_loader;

    localparam int unsigned MEM_WORDS = 1024;
    localparam logic [31:0] BASE_ADDR = 32'h0000_1000;
    localparam int          LIMIT     = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    prog_loader #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_rst(core_rst), .busy(busy),
        .done(done), .err(err)
    );

    int          total = 0;
    int          bad = 0;
    logic [7:0]  stream_q[$];
    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];
    bit          exp_done;
    bit          exp_err;
    bit          fell_seen = 1'b0;
    int          cyc = 0;
    int          last_we_cyc = 0;
    int          fall_cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write monitor: records every strobe and checks back-pressure during it
    always @(negedge clk) begin
        cyc++;
        if (mem_we === 1'b1) begin
            wr_q.push_back({mem_addr, mem_wdata});
            last_we_cyc = cyc;
            check_val("ready_in_write", 32'(in_ready), 32'd0);
        end
        if ((core_rst === 1'b0) && !fell_seen) begin
            fell_seen = 1'b1;
            fall_cyc  = cyc;
        end
    end

    task automatic do_reset(input bit with_byte, input logic [7:0] b);
        @(negedge clk);
        rst = 1'b1;
        in_valid = with_byte;
        in_data = b;
        @(negedge clk);
        check_val("rst_core_rst", 32'(core_rst), 32'd1);
        check_val("rst_no_we", 32'(mem_we), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        wr_q.delete();
        fell_seen = 1'b0;
    endtask

    task automatic push_header(input logic [31:0] n);
        stream_q.delete();
        stream_q.push_back(n[7:0]);
        stream_q.push_back(n[15:8]);
        stream_q.push_back(n[23:16]);
        stream_q.push_back(n[31:24]);
    endtask

    task automatic append_csum(input bit good);
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int k = 4; k < stream_q.size(); k++) x ^= stream_q[k];
        stream_q.push_back(good ? x : (x ^ 8'(1 + $urandom_range(0, 254))));
`else
        if (good) stream_q.push_back(8'h00);
        if (good) void'(stream_q.pop_back());
`endif
    endtask

    task automatic make_image(input int n, input bit good);
        push_header(32'(n));
        for (int k = 0; k < 4 * n; k++) stream_q.push_back(8'($urandom));
        append_csum(good);
    endtask

    // Reference: what a correct loader must write for this byte image
    task automatic compute_model();
        logic [31:0] n;
        logic [7:0]  x;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = {stream_q[3], stream_q[2], stream_q[1], stream_q[0]};
        if (n > MEM_WORDS) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < int'(n); i++)
                exp_q.push_back({BASE_ADDR + 32'(4 * i), stream_q[4 + 4*i + 3],
                                 stream_q[4 + 4*i + 2], stream_q[4 + 4*i + 1], stream_q[4 + 4*i]});
`ifdef PROG_LOADER_CHECKSUM_EN
            x = 8'h00;
            for (int k = 4; k < 4 + 4 * int'(n); k++) x ^= stream_q[k];
            if (stream_q[4 + 4 * int'(n)] == x) exp_done = 1'b1;
            else exp_err = 1'b1;
`else
            x = 8'h00;
            exp_done = (x == 8'h00);
`endif
        end
    endtask

    // mode 0: contiguous, 1: valid toggles every cycle, 2: random gaps
    task automatic send_stream(input int mode);
        int  idx = 0;
        int  budget = 0;
        bit  tog = 1'b1;
        bit  v;
        bit  hs;
        while ((idx < stream_q.size()) && (budget < LIMIT)) begin
            @(negedge clk);
            case (mode)
                0: v = 1'b1;
                1: v = tog;
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            tog = ~tog;
            in_valid = v;
            in_data = v ? stream_q[idx] : 8'($urandom);
            hs = v && (in_ready === 1'b1);
            @(posedge clk);
            if (hs) idx++;
            budget++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (idx < stream_q.size()) check_val("stream_timeout", 32'(idx), 32'(stream_q.size()));
    endtask

    task automatic compare_results();
        int nwr;
        check_val("wr_count", 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; (i < wr_q.size()) && (i < exp_q.size()); i++) begin
            check_val("wr_addr", wr_q[i][63:32], exp_q[i][63:32]);
            check_val("wr_data", wr_q[i][31:0], exp_q[i][31:0]);
        end
        check_val("done", 32'(done), 32'(exp_done));
        check_val("err", 32'(err), 32'(exp_err));
        check_val("core_rst", 32'(core_rst), 32'(!exp_done));
        check_val("busy_end", 32'(busy), 32'd0);
        check_val("ready_end", 32'(in_ready), 32'd0);
`ifndef PROG_LOADER_CHECKSUM_EN
        if (exp_done && (exp_q.size() > 0))
            check_val("core_rst_lat", 32'(fall_cyc - last_we_cyc), 32'd1);
`endif
        nwr = wr_q.size();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = 8'($urandom);
            check_val("ready_closed", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_val("no_extra_wr", 32'(wr_q.size()), 32'(nwr));
        check_val("status_hold", 32'({done, err}), 32'({exp_done, exp_err}));
    endtask

    task automatic run_case(input int mode);
        compute_model();
        send_stream(mode);
        repeat (3) @(negedge clk);
        compare_results();
    endtask

    initial begin
        do_reset(1'b0, 8'h00);
        check_val("rst_we", 32'(mem_we), 32'd0);
        check_val("rst_addr", mem_addr, BASE_ADDR);
        check_val("rst_wdata", mem_wdata, 32'd0);
        check_val("rst_core", 32'(core_rst), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_ready", 32'(in_ready), 32'd1);

        // Two known instructions
        push_header(32'd2);
        stream_q.push_back(8'h13); stream_q.push_back(8'h00); stream_q.push_back(8'h50); stream_q.push_back(8'h00);
        stream_q.push_back(8'h93); stream_q.push_back(8'h00); stream_q.push_back(8'h10); stream_q.push_back(8'h00);
        append_csum(1'b1);
        run_case(0);
        if (wr_q.size() == 2) begin
            check_val("p1_w0", wr_q[0][31:0], 32'h0050_0013);
            check_val("p1_w1", wr_q[1][31:0], 32'h0010_0093);
            check_val("p1_a1", wr_q[1][63:32], BASE_ADDR + 32'd4);
        end else begin
            check_val("p1_count", 32'(wr_q.size()), 32'd2);
        end

        // Empty image
        do_reset(1'b0, 8'h00);
        push_header(32'd0);
        append_csum(1'b1);
        run_case(0);

        // Oversized image
        do_reset(1'b0, 8'h00);
        push_header(32'(MEM_WORDS + 1));
        run_case(0);
        check_val("big_held", 32'(fell_seen), 32'd0);

        // Valid toggling every cycle
        do_reset(1'b0, 8'h00);
        make_image(3, 1'b1);
        run_case(1);

        // Reset after two payload bytes, then a fresh one-word image
        do_reset(1'b0, 8'h00);
        push_header(32'd1);
        stream_q.push_back(8'h11); stream_q.push_back(8'h22);
        send_stream(0);
        check_val("busy_mid", 32'(busy), 32'd1);
        check_val("partial_no_we", 32'(wr_q.size()), 32'd0);
        do_reset(1'b1, 8'h33);
        push_header(32'd1);
        stream_q.push_back(8'hEF); stream_q.push_back(8'hBE); stream_q.push_back(8'hAD); stream_q.push_back(8'hDE);
        append_csum(1'b1);
        run_case(2);
        if (wr_q.size() > 0) check_val("deadbeef", wr_q[0][31:0], 32'hDEAD_BEEF);
        else check_val("deadbeef_cnt", 32'(wr_q.size()), 32'd1);

        // Reset coinciding with the fourth byte of a word
        do_reset(1'b0, 8'h00);
        push_header(32'd1);
        stream_q.push_back(8'h01); stream_q.push_back(8'h02); stream_q.push_back(8'h03);
        send_stream(0);
        check_val("pre4_no_we", 32'(wr_q.size()), 32'd0);
        do_reset(1'b1, 8'h04);
        check_val("rst4_no_wr", 32'(wr_q.size()), 32'd0);

        // Largest image
        do_reset(1'b0, 8'h00);
        make_image(int'(MEM_WORDS), 1'b1);
        run_case(0);

        // Random images, random pacing
        for (int t = 0; t < 6; t++) begin
            do_reset(1'b0, 8'h00);
            make_image($urandom_range(1, 6), ($urandom_range(0, 2) != 0));
            run_case($urandom_range(0, 2));
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        for (int t = 0; t < 2; t++) begin
            do_reset(1'b0, 8'h00);
            push_header(32'd1);
            stream_q.push_back(8'hAA); stream_q.push_back(8'hBB); stream_q.push_back(8'hCC); stream_q.push_back(8'hDD);
            stream_q.push_back((t == 0) ? 8'h00 : 8'h01);
            run_case(0);
            check_val("csum_fixed", 32'({done, err}), (t == 0) ? 32'd2 : 32'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
